lfsr_capture: RTL and testbench

LFSR_CAPTURE -- requirements
Module: lfsr_capture

---
 rtl/lfsr_capture.sv | 158 +++++++++++++++
 tb/tb_lfsr_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_capture.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_capture
//  Description : Synchronises the GPS 1PPS gate, issues a one-cycle cutoff
//                pulse to the lfsr32 counter, and captures the final count of
//                each complete gate interval into a show-ahead FIFO. Each
//                capture carries a sequence number, and a sticky overflow flag
//                records dropped captures.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_capture #(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pps,
    input  logic [31:0]              count,
    output logic                     cutoff,
    output logic [31:0]              out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    // pps synchroniser plus the edge-detect stage
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // gate pulse and gate bookkeeping
    logic             r_cutoff;
    logic             r_first;
    logic [SEQ_W-1:0] r_seq;

    // capture FIFO storage and control
    logic [31:0]        r_mem_data [DEPTH];
    logic [SEQ_W-1:0]   r_mem_seq  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;

    logic w_edge;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_drop;

    // A rising edge is seen when the synchronised level is high but was low
    // one cycle earlier.
    assign w_edge  = r_s2 & ~r_s3;
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL);

    // The partial gate that ends at the first cutoff after reset is ignored.
    assign w_push  = r_cutoff & ~r_first;
    assign w_pop   = ~w_empty & out_ready;

    // A pop on the same edge frees the slot the push needs, so a full FIFO
    // still accepts the capture in that case.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Synchroniser resets high so a pps already high at release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= pps;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Registered one-cycle cutoff pulse on each detected pps rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cutoff <= 1'b0;
        end else begin
            r_cutoff <= w_edge;
        end
    end

    // First-gate flag and sequence counter; dropped captures still advance it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 1'b1;
            r_seq   <= '0;
        end else if (r_cutoff) begin
            if (r_first) begin
                r_first <= 1'b0;
            end else begin
                r_seq <= r_seq + SEQ_W'(1);
            end
        end
    end

    // FIFO storage write; contents need no reset because level gates them
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr] <= count;
            r_mem_seq[r_wr_ptr]  <= r_seq;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign cutoff    = r_cutoff;
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? 32'd0 : r_mem_data[r_rd_ptr];
    assign out_seq   = w_empty ? '0    : r_mem_seq[r_rd_ptr];
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_capture
//  Description : Self-checking bench for lfsr_capture. Captures expected by
//                the gate model are queued; a monitor pops and compares each
//                entry the DUT hands over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_capture;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 8;

    typedef struct packed {
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pps;
    logic [31:0]            count;
    logic                   cutoff;
    logic [31:0]            out_data;
    logic [SEQ_W-1:0]       out_seq;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic                   clr_ovf;

    ent_t             sb[$];
    int               tests   = 0;
    int               fails   = 0;
    int               cut_cnt = 0;
    bit               first_gate;
    logic [SEQ_W-1:0] exp_seq;

    lfsr_capture #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pps       (pps),
        .count     (count),
        .cutoff    (cutoff),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT hands over its head entry.
    task automatic monitor();
        ent_t e;
        forever begin
            @(negedge clk);
            if (cutoff === 1'b1) cut_cnt++;
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_entry: got data %h seq %0d, expected none",
                             out_data, out_seq);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_seq !== e.seq) begin
                        fails++;
                        $display("FAIL entry: got data %h seq %0d expected data %h seq %0d",
                                 out_data, out_seq, e.data, e.seq);
                    end
                end
            end
        end
    endtask

    task automatic do_reset(input logic pps_lvl);
        rst = 1'b1; pps = pps_lvl; count = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        sb.delete();
        first_gate = 1'b1;
        exp_seq = '0;
        repeat (4) tick();
    endtask

    // One pps pulse; count holds val through the cutoff cycle. Optional pop
    // and overflow clear are asserted only during the cutoff cycle.
    task automatic gate(input logic [31:0] val, input bit pop_on_cut, input bit clr_on_cut);
        int  n;
        bit  saved_ready;
        count = val;
        pps = 1'b1;
        n = 0;
        tick();
        while (cutoff !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        pps = 1'b0;
        if (cutoff !== 1'b1) begin
            chk("gate_timeout", {31'd0, cutoff}, 32'd1);
        end else begin
            saved_ready = out_ready;
            if (pop_on_cut) out_ready = 1'b1;
            if (clr_on_cut) clr_ovf = 1'b1;
            if (first_gate) begin
                first_gate = 1'b0;
            end else begin
                if (!(sb.size() == DEPTH && !out_ready))
                    sb.push_back('{data: val, seq: exp_seq});
                exp_seq++;
            end
            tick();
            out_ready = saved_ready;
            clr_ovf = 1'b0;
        end
        repeat (4) tick();
    endtask

    initial begin
        int c0;
        int n;
        fork
            monitor();
        join_none

        // Reset state
        do_reset(1'b0);
        chk("rst_cutoff",   {31'd0, cutoff},    32'd0);
        chk("rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_level",    {29'd0, level},     32'd0);
        chk("rst_overflow", {31'd0, overflow},  32'd0);
        chk("rst_data",     out_data,           32'd0);
        chk("rst_seq",      {24'd0, out_seq},   32'd0);

        // First gate: cutoff two edges after first sampling, no capture
        pps = 1'b1;
        tick(); chk("lat_k",   {31'd0, cutoff}, 32'd0);
        tick(); chk("lat_k1",  {31'd0, cutoff}, 32'd0);
        tick(); chk("lat_k2",  {31'd0, cutoff}, 32'd1);
        pps = 1'b0;
        tick(); chk("lat_one", {31'd0, cutoff}, 32'd0);
        first_gate = 1'b0;
        repeat (4) tick();
        chk("first_valid", {31'd0, out_valid}, 32'd0);
        chk("first_level", {29'd0, level},     32'd0);

        // Second gate captures
        gate(32'hA300_0000, 1'b0, 1'b0);
        chk("cap_valid", {31'd0, out_valid}, 32'd1);
        chk("cap_data",  out_data,           32'hA300_0000);
        chk("cap_seq",   {24'd0, out_seq},   32'd0);
        chk("cap_level", {29'd0, level},     32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Five gates into a depth-4 FIFO with no consumer
        do_reset(1'b0);
        gate(32'h0BAD_0000, 1'b0, 1'b0);
        gate(32'h1111_1111, 1'b0, 1'b0);
        gate(32'h2222_2222, 1'b0, 1'b0);
        gate(32'h3333_3333, 1'b0, 1'b0);
        gate(32'h4444_4444, 1'b0, 1'b0);
        gate(32'h5555_5555, 1'b0, 1'b0);
        chk("full_level",    {29'd0, level},    32'd4);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        chk("full_head_seq", {24'd0, out_seq},  32'd0);
        out_ready = 1'b1;
        n = 0;
        while (level != 0 && n < 20) begin tick(); n++; end
        chk("drain_level", {29'd0, level}, 32'd0);
        out_ready = 1'b0;
        gate(32'h6666_6666, 1'b0, 1'b0);
        chk("gap_seq",  {24'd0, out_seq}, 32'd5);
        chk("gap_data", out_data,         32'h6666_6666);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Full FIFO with pop in the cutoff cycle, then drop racing a clear
        do_reset(1'b0);
        gate(32'h0BAD_0001, 1'b0, 1'b0);
        gate(32'h7000_0000, 1'b0, 1'b0);
        gate(32'h7000_0001, 1'b0, 1'b0);
        gate(32'h7000_0002, 1'b0, 1'b0);
        gate(32'h7000_0003, 1'b0, 1'b0);
        gate(32'h7000_0004, 1'b1, 1'b0);
        chk("pp_level",    {29'd0, level},    32'd4);
        chk("pp_overflow", {31'd0, overflow}, 32'd0);
        chk("pp_head_seq", {24'd0, out_seq},  32'd1);
        gate(32'h7000_0005, 1'b0, 1'b1);
        chk("set_wins", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        n = 0;
        while (level != 0 && n < 20) begin tick(); n++; end
        chk("pp_drain", {29'd0, level}, 32'd0);

        // pps held high for 100 cycles gives one cutoff and one capture
        c0 = cut_cnt;
        count = 32'hCAFE_F00D;
        sb.push_back('{data: 32'hCAFE_F00D, seq: exp_seq});
        exp_seq++;
        pps = 1'b1;
        repeat (100) tick();
        pps = 1'b0;
        repeat (5) tick();
        chk("held_one_cut", cut_cnt - c0, 32'd1);
        chk("held_drained", {29'd0, level}, 32'd0);

        // pps high through reset release gives no cutoff
        do_reset(1'b1);
        c0 = cut_cnt;
        repeat (20) tick();
        pps = 1'b0;
        repeat (5) tick();
        chk("rst_high_no_cut", cut_cnt - c0, 32'd0);

        // Sequence wrap at 2^SEQ_W
        gate(32'h0BAD_0002, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) gate(32'h0100_0000 + i, 1'b0, 1'b0);
        repeat (2) tick();
        out_ready = 1'b0;
        gate(32'hFFFF_0000, 1'b0, 1'b0);
        gate(32'hFFFF_0001, 1'b0, 1'b0);
        chk("wrap_head_seq", {24'd0, out_seq}, 32'd255);
        chk("wrap_level",    {29'd0, level},   32'd2);
        out_ready = 1'b1;
        tick();
        chk("wrap_next_seq", {24'd0, out_seq}, 32'd0);
        repeat (3) tick();
        out_ready = 1'b0;

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
